cpu_boot_loader: RTL and testbench

Upstream host-side block that feeds the 5-stage RISC-V `cpu` top through its external memory ports and its `enable` input.
- Accepts a 32-bit word stream (valid/ready) carrying a header, program and data image.
- Writes the program into instruction memory and the data into data memory.
- Asserts the CPU run enable for a programmed number of cycles.
- Streams a programmed number of data-memory words back out (valid/ready).

---
 rtl/cpu_boot_loader.sv | 190 +++++++++++++++++++
 tb/tb_cpu_boot_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_boot_loader.sv
// Host-side loader for the 5-stage cpu: parses a header/program/data word stream,
// fills instruction and data memory, runs the core for R cycles, then dumps data memory.
module cpu_boot_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        m_valid,
    output logic [63:0] m_data,
    input  logic        m_ready,
    output logic        cpu_enable,
    output logic [63:0] imem_addr,
    output logic        imem_wen,
    output logic        imem_ren,
    output logic [31:0] imem_wdata,
    output logic [63:0] dmem_addr,
    output logic        dmem_wen,
    output logic        dmem_ren,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE, HDR1, HDR2, LD_I, LD_D_LO, LD_D_HI,
        RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE, ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] nI_q, nI_d, nD_q, nD_d, nO_q, nO_d, cnt_q, cnt_d;
    logic [31:0] runCnt_q, runCnt_d, lo_q, lo_d, imemWdata_q, imemWdata_d;
    logic [63:0] imemAddr_q, imemAddr_d, dmemAddr_q, dmemAddr_d;
    logic [63:0] dmemWdata_q, dmemWdata_d, mData_q, mData_d;
    logic        imemWen_q, imemWen_d, dmemWen_q, dmemWen_d, cpuEn_q, cpuEn_d;
    logic        accept, headerBad;

    assign s_ready    = state_q inside {IDLE, HDR1, HDR2, LD_I, LD_D_LO, LD_D_HI};
    assign accept     = s_valid && s_ready;
    assign headerBad  = (32'(nI_q) > IMEM_WORDS) || (32'(nD_q) > DMEM_WORDS)
                      || (32'(s_data[15:0]) > DMEM_WORDS);

    assign m_valid    = (state_q == DUMP_OUT);
    assign m_data     = mData_q;
    assign cpu_enable = cpuEn_q;
    assign imem_addr  = imemAddr_q;
    assign imem_wen   = imemWen_q;
    assign imem_ren   = 1'b0;
    assign imem_wdata = imemWdata_q;
    assign dmem_ren   = (state_q == DUMP_RD);
    assign dmem_addr  = dmem_ren ? {45'd0, cnt_q, 3'b000} : dmemAddr_q;
    assign dmem_wen   = dmemWen_q;
    assign dmem_wdata = dmemWdata_q;
    assign busy       = !(state_q inside {IDLE, DONE, ERR});
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            nI_q        <= '0;
            nD_q        <= '0;
            nO_q        <= '0;
            cnt_q       <= '0;
            runCnt_q    <= '0;
            lo_q        <= '0;
            imemWdata_q <= '0;
            imemAddr_q  <= '0;
            dmemAddr_q  <= '0;
            dmemWdata_q <= '0;
            mData_q     <= '0;
            imemWen_q   <= 1'b0;
            dmemWen_q   <= 1'b0;
            cpuEn_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            nI_q        <= nI_d;
            nD_q        <= nD_d;
            nO_q        <= nO_d;
            cnt_q       <= cnt_d;
            runCnt_q    <= runCnt_d;
            lo_q        <= lo_d;
            imemWdata_q <= imemWdata_d;
            imemAddr_q  <= imemAddr_d;
            dmemAddr_q  <= dmemAddr_d;
            dmemWdata_q <= dmemWdata_d;
            mData_q     <= mData_d;
            imemWen_q   <= imemWen_d;
            dmemWen_q   <= dmemWen_d;
            cpuEn_q     <= cpuEn_d;
        end
    end

    // Empty phases are skipped by choosing the first non-empty successor directly.
    // RUN is always entered so the final load write retires before the core starts.
    always_comb begin
        state_d     = state_q;
        nI_d        = nI_q;
        nD_d        = nD_q;
        nO_d        = nO_q;
        cnt_d       = cnt_q;
        runCnt_d    = runCnt_q;
        lo_d        = lo_q;
        imemWdata_d = imemWdata_q;
        imemAddr_d  = imemAddr_q;
        dmemAddr_d  = dmemAddr_q;
        dmemWdata_d = dmemWdata_q;
        mData_d     = mData_q;
        imemWen_d   = 1'b0;
        dmemWen_d   = 1'b0;
        cpuEn_d     = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                nI_d    = s_data[15:0];
                nD_d    = s_data[31:16];
                state_d = HDR1;
            end
            HDR1: if (accept) begin
                runCnt_d = s_data;
                state_d  = HDR2;
            end
            HDR2: if (accept) begin
                nO_d  = s_data[15:0];
                cnt_d = '0;
                if (headerBad)        state_d = ERR;
                else if (nI_q != '0)  state_d = LD_I;
                else if (nD_q != '0)  state_d = LD_D_LO;
                else                  state_d = RUN;
            end
            LD_I: if (accept) begin
                imemWen_d   = 1'b1;
                imemAddr_d  = {46'd0, cnt_q, 2'b00};
                imemWdata_d = s_data;
                if (cnt_q == nI_q - 16'd1) begin
                    cnt_d   = '0;
                    state_d = (nD_q != '0) ? LD_D_LO : RUN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            LD_D_LO: if (accept) begin
                lo_d    = s_data;
                state_d = LD_D_HI;
            end
            LD_D_HI: if (accept) begin
                dmemWen_d   = 1'b1;
                dmemAddr_d  = {45'd0, cnt_q, 3'b000};
                dmemWdata_d = {s_data, lo_q};
                if (cnt_q == nD_q - 16'd1) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = LD_D_LO;
                end
            end
            RUN: begin
                if (runCnt_q != '0) begin
                    cpuEn_d  = 1'b1;
                    runCnt_d = runCnt_q - 32'd1;
                end else begin
                    cnt_d   = '0;
                    state_d = (nO_q != '0) ? DUMP_RD : DONE;
                end
            end
            DUMP_RD:   state_d = DUMP_WAIT;
            DUMP_WAIT: begin
                mData_d = dmem_rdata;
                state_d = DUMP_OUT;
            end
            DUMP_OUT: if (m_ready) begin
                if (cnt_q == nO_q - 16'd1) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = DUMP_RD;
                end
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Randomized self-checking bench for cpu_boot_loader: a behavioural image model predicts
// memory writes, run length and dump contents; a small data-memory model answers reads.
module tb_cpu_boot_loader;

    localparam int IMEM_WORDS = 512;
    localparam int DMEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_ready, m_valid, m_ready, cpu_enable;
    logic [31:0] s_data, imem_wdata;
    logic [63:0] m_data, imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
    logic        imem_wen, imem_ren, dmem_wen, dmem_ren, busy, done, err;

    always #5 clk = ~clk;

    cpu_boot_loader #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .cpu_enable(cpu_enable),
        .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren),
        .imem_wdata(imem_wdata), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
        .dmem_ren(dmem_ren), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .busy(busy), .done(done), .err(err)
    );

    function automatic logic [63:0] memPattern(input int i);
        return {32'hC0DE0000 | 32'(i), ~32'(i)};
    endfunction

    // Data memory as the core would present it: one-cycle read latency.
    logic [63:0] envMem [0:1023];
    bit          envWritten [0:1023];
    always @(posedge clk) begin
        if (dmem_wen) begin
            envMem[dmem_addr[12:3]]     <= dmem_wdata;
            envWritten[dmem_addr[12:3]] <= 1'b1;
        end
        if (dmem_ren)
            dmem_rdata <= envWritten[dmem_addr[12:3]] ? envMem[dmem_addr[12:3]]
                                                      : memPattern(int'(dmem_addr[12:3]));
        else
            dmem_rdata <= 64'h0;
    end

    logic [63:0] obsImemAddr[$], obsDmemAddr[$], obsDmemData[$], obsRenAddr[$], obsDump[$];
    logic [31:0] obsImemData[$];
    int          enCycles = 0, enRises = 0, overlapCnt = 0, imemRenCnt = 0, unstableCnt = 0;
    logic        prevEn = 1'b0, prevHold = 1'b0;
    logic [63:0] prevMData = 64'h0;

    always @(negedge clk) begin
        if (imem_wen) begin
            obsImemAddr.push_back(imem_addr);
            obsImemData.push_back(imem_wdata);
        end
        if (dmem_wen) begin
            obsDmemAddr.push_back(dmem_addr);
            obsDmemData.push_back(dmem_wdata);
        end
        if (dmem_ren) obsRenAddr.push_back(dmem_addr);
        if (cpu_enable) enCycles++;
        if (cpu_enable && !prevEn) enRises++;
        if (cpu_enable && (imem_wen || dmem_wen || dmem_ren)) overlapCnt++;
        if (imem_ren) imemRenCnt++;
        if (prevHold && m_valid && m_data !== prevMData) unstableCnt++;
        if (m_valid && m_ready) obsDump.push_back(m_data);
        prevHold  = m_valid && !m_ready;
        prevMData = m_data;
        prevEn    = cpu_enable;
    end

    // m_ready either cycles 0,0,1 regardless of m_valid, or is random.
    int mReadyMode = 0;
    initial begin
        int phase = 0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mReadyMode == 0) begin
                m_ready = (phase % 3 == 2);
                phase++;
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    int errors = 0, checks = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] w, input int gapMax);
        int  waitCyc = 0;
        bit  ok = 1'b0;
        repeat ($urandom_range(0, gapMax)) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = w;
        while (!ok && waitCyc < 200) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            waitCyc++;
        end
        s_valid = 1'b0;
        s_data  = $urandom;
        checkOutput("wordAccepted", 64'(ok), 64'd1);
    endtask

    logic [31:0] imgInstr[$];
    logic [63:0] imgData[$];
    logic [63:0] refMem [0:1023];
    int imgR, imgNo;
    int bImem, bDmem, bRen, bDump, bEn, bRise, bOverlap, bImemRen, bUnstable;

    task automatic snapBases();
        bImem = obsImemAddr.size(); bDmem = obsDmemAddr.size(); bRen = obsRenAddr.size();
        bDump = obsDump.size(); bEn = enCycles; bRise = enRises; bOverlap = overlapCnt;
        bImemRen = imemRenCnt; bUnstable = unstableCnt;
    endtask

    task automatic loadImage(input int gapMax);
        applyStimulus({16'(imgData.size()), 16'(imgInstr.size())}, gapMax);
        applyStimulus(32'(imgR), gapMax);
        applyStimulus({16'($urandom), 16'(imgNo)}, gapMax);
        foreach (imgInstr[k]) applyStimulus(imgInstr[k], gapMax);
        foreach (imgData[k]) begin
            applyStimulus(imgData[k][31:0], gapMax);
            applyStimulus(imgData[k][63:32], gapMax);
            refMem[k] = imgData[k];
        end
    endtask

    task automatic runImage(input int gapMax);
        int c = 0;
        applyReset();
        snapBases();
        loadImage(gapMax);
        while (!done && c < 3000) begin
            @(negedge clk);
            #1;
            c++;
        end
        checkOutput("doneReached", 64'(done), 64'd1);
        checkOutput("doneBusy", 64'(busy), 64'd0);
        checkOutput("doneSReady", 64'(s_ready), 64'd0);
        checkOutput("doneErr", 64'(err), 64'd0);
        checkOutput("imemWrCount", 64'(obsImemAddr.size() - bImem), 64'(imgInstr.size()));
        for (int k = 0; k < imgInstr.size() && bImem + k < obsImemAddr.size(); k++) begin
            checkOutput($sformatf("imemAddr%0d", k), obsImemAddr[bImem + k], 64'(4 * k));
            checkOutput($sformatf("imemData%0d", k), 64'(obsImemData[bImem + k]), 64'(imgInstr[k]));
        end
        checkOutput("dmemWrCount", 64'(obsDmemAddr.size() - bDmem), 64'(imgData.size()));
        for (int k = 0; k < imgData.size() && bDmem + k < obsDmemAddr.size(); k++) begin
            checkOutput($sformatf("dmemAddr%0d", k), obsDmemAddr[bDmem + k], 64'(8 * k));
            checkOutput($sformatf("dmemData%0d", k), obsDmemData[bDmem + k], imgData[k]);
        end
        checkOutput("enableCycles", 64'(enCycles - bEn), 64'(imgR));
        checkOutput("enableRuns", 64'(enRises - bRise), 64'(imgR > 0 ? 1 : 0));
        checkOutput("enableOverlap", 64'(overlapCnt - bOverlap), 64'd0);
        checkOutput("imemRen", 64'(imemRenCnt - bImemRen), 64'd0);
        checkOutput("mDataStable", 64'(unstableCnt - bUnstable), 64'd0);
        checkOutput("dumpCount", 64'(obsDump.size() - bDump), 64'(imgNo));
        for (int j = 0; j < imgNo && bDump + j < obsDump.size(); j++)
            checkOutput($sformatf("dump%0d", j), obsDump[bDump + j], refMem[j]);
        for (int j = 0; j < imgNo && bRen + j < obsRenAddr.size(); j++)
            checkOutput($sformatf("renAddr%0d", j), obsRenAddr[bRen + j], 64'(8 * j));
    endtask

    task automatic errorHeader(input int nI, input int nD, input int nO);
        applyReset();
        snapBases();
        applyStimulus({16'(nD), 16'(nI)}, 0);
        applyStimulus(32'd10, 0);
        applyStimulus({16'hFFFF, 16'(nO)}, 0);
        @(negedge clk);
        #1;
        checkOutput("errFlag", 64'(err), 64'd1);
        checkOutput("errSReady", 64'(s_ready), 64'd0);
        checkOutput("errBusy", 64'(busy), 64'd0);
        s_valid = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        s_valid = 1'b0;
        checkOutput("errSticky", 64'(err), 64'd1);
        checkOutput("errDone", 64'(done), 64'd0);
        checkOutput("errNoWrites", 64'(obsImemAddr.size() - bImem + obsDmemAddr.size() - bDmem), 64'd0);
        checkOutput("errNoEnable", 64'(enCycles - bEn), 64'd0);
    endtask

    task automatic randomImage(input int maxI, input int maxD);
        imgInstr.delete();
        imgData.delete();
        repeat ($urandom_range(0, maxI)) imgInstr.push_back($urandom);
        repeat ($urandom_range(0, maxD)) imgData.push_back({$urandom, $urandom});
    endtask

    initial begin
        int c;
        for (int i = 0; i < 1024; i++) refMem[i] = memPattern(i);
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = 32'h0;
        applyReset();
        @(negedge clk);
        #1;
        checkOutput("rstSReady", 64'(s_ready), 64'd1);
        checkOutput("rstStrobes", {56'd0, m_valid, cpu_enable, imem_wen, imem_ren,
                                   dmem_wen, dmem_ren, busy, done}, 64'd0);
        checkOutput("rstErr", 64'(err), 64'd0);
        checkOutput("rstMData", m_data, 64'd0);
        checkOutput("rstAddrs", imem_addr | dmem_addr, 64'd0);

        imgInstr = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        imgData.delete();
        imgR = 20; imgNo = 0;
        runImage(0);

        imgInstr.delete();
        imgData = '{64'h2222222211111111, 64'h4444444433333333};
        imgR = 4; imgNo = 2;
        runImage(0);

        errorHeader(513, 0, 0);
        errorHeader(0, 0, 1025);

        mReadyMode = 1;
        randomImage(12, 3);
        imgR = 7; imgNo = 5;
        runImage(3);

        // Reset during the fifth enable cycle, then reload from scratch.
        applyReset();
        randomImage(4, 2);
        imgR = 20; imgNo = 3;
        loadImage(1);
        bEn = enCycles;
        c = 0;
        while (enCycles - bEn < 5 && c < 500) begin
            @(negedge clk);
            #1;
            c++;
        end
        checkOutput("enBeforeReset", 64'(enCycles - bEn), 64'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("midRstEnable", 64'(cpu_enable), 64'd0);
        checkOutput("midRstSReady", 64'(s_ready), 64'd1);
        checkOutput("midRstBusy", 64'(busy), 64'd0);
        checkOutput("midRstEnCount", 64'(enCycles - bEn), 64'd5);

        for (int r = 0; r < 4; r++) begin
            randomImage(16, 8);
            imgR = $urandom_range(0, 25);
            imgNo = $urandom_range(0, 10);
            runImage(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
